// File: rtl/axis_pkg.sv
// axis_pkg -- shared definitions for the AXIS packet arbiter and its buffer.
//   TUSER field map : LEN[15:0], SPT[23:16], DPT[31:24]
//   arb_state_e     : arbiter FSM states (IDLE = arbitrate, PKT = packet owned)
//   rr_pick()       : round-robin selection helper
package axis_pkg;
  localparam int LEN_LSB   = 0;
  localparam int SPT_LSB   = 16;
  localparam int DPT_LSB   = 24;
  localparam int FLD_W     = 8;
  localparam int MAX_PORTS = 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} arb_state_e;

  // Index of the first set bit of req strictly after ptr, wrapping modulo n.
  // Returns 0 when req is empty; callers only use the result when |req.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] req,
                                 input int ptr, input int n);
    int sel, idx;
    logic found;
    sel   = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      idx = (ptr + k) % n;
      if (!found && k <= n && req[idx[2:0]]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2 -- 2-entry registered AXIS buffer for an opaque W-bit beat.
//   i_clk/i_rst             : clock, async active-high reset (flushes entries)
//   i_data/i_valid/o_ready  : upstream side; o_ready = not full
//   o_data/o_valid/i_ready  : downstream side, driven straight from the head reg
// Two entries allow one push per cycle with a fully registered output.
module axis_skid2 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic [W-1:0] r_head, r_tail;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;

  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: if (w_push) begin
          r_head <= i_data;
          r_cnt  <= 2'd1;
        end
        2'd1: begin
          if (w_push && w_pop) r_head <= i_data;
          else if (w_push) begin
            r_tail <= i_data;
            r_cnt  <= 2'd2;
          end else if (w_pop) r_cnt <= 2'd0;
        end
        // full: no push possible, a pop promotes the tail
        default: if (w_pop) begin
          r_head <= r_tail;
          r_cnt  <= 2'd1;
        end
      endcase
    end
  end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter -- packet-granular round-robin mux of NPORTS AXIS masters
// onto one AXIS slave. A granted port owns the output until its TLAST beat is
// accepted; every packet costs one arbitration cycle in IDLE.
//   ACLK/ARESET        : clock, async active-high reset
//   S_AXIS_*           : NPORTS packed input streams (port i at slice i)
//   M_AXIS_*           : merged output stream, from a 2-entry buffer
//   PORT_EN            : arbitration enable mask, sampled in IDLE only
//   GRANT/BUSY         : one-hot owner / packet in progress
//   PKT_CNT            : per-port completed-packet counters (wrapping)
module axis_pkt_arbiter
  import axis_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 128,
  parameter int STAMP_SPT = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NPORTS*DATA_W-1:0]  S_AXIS_TDATA,
  input  logic [NPORTS*DATA_W/8-1:0] S_AXIS_TSTRB,
  input  logic [NPORTS*USER_W-1:0]  S_AXIS_TUSER,
  input  logic [NPORTS-1:0]         S_AXIS_TLAST,
  input  logic [NPORTS-1:0]         S_AXIS_TVALID,
  output logic [NPORTS-1:0]         S_AXIS_TREADY,
  output logic [DATA_W-1:0]         M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]       M_AXIS_TSTRB,
  output logic [USER_W-1:0]         M_AXIS_TUSER,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  input  logic [NPORTS-1:0]         PORT_EN,
  output logic [NPORTS-1:0]         GRANT,
  output logic                      BUSY,
  output logic [NPORTS*CNT_W-1:0]   PKT_CNT
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int BEAT_W = 1 + USER_W + STRB_W + DATA_W;

  logic [NPORTS-1:0][DATA_W-1:0] w_tdata;
  logic [NPORTS-1:0][STRB_W-1:0] w_tstrb;
  logic [NPORTS-1:0][USER_W-1:0] w_tuser;

  for (genvar i = 0; i < NPORTS; i++) begin : g_slice
    assign w_tdata[i] = S_AXIS_TDATA[i*DATA_W +: DATA_W];
    assign w_tstrb[i] = S_AXIS_TSTRB[i*STRB_W +: STRB_W];
    assign w_tuser[i] = S_AXIS_TUSER[i*USER_W +: USER_W];
  end

  arb_state_e                   r_state, w_state_nxt;
  logic [IDX_W-1:0]             r_gidx, w_gidx_nxt, r_rr, w_rr_nxt;
  logic [NPORTS-1:0]            w_req;
  logic                         w_in_vld, w_buf_rdy, w_acc_last;
  logic [USER_W-1:0]            w_user;
  logic [BEAT_W-1:0]            w_beat_in, w_beat_out;
  logic [NPORTS-1:0][CNT_W-1:0] r_cnt;

  assign w_req      = S_AXIS_TVALID & PORT_EN;
  assign w_in_vld   = (r_state == ST_PKT) & S_AXIS_TVALID[r_gidx];
  assign w_acc_last = w_in_vld & w_buf_rdy & S_AXIS_TLAST[r_gidx];
  assign BUSY       = (r_state == ST_PKT);

  always_comb begin
    S_AXIS_TREADY = '0;
    GRANT         = '0;
    if (r_state == ST_PKT) begin
      S_AXIS_TREADY[r_gidx] = w_buf_rdy;
      GRANT[r_gidx]         = 1'b1;
    end
  end

  // Source-port stamp is applied before the beat enters the buffer.
  always_comb begin
    w_user = w_tuser[r_gidx];
    if (STAMP_SPT != 0) w_user[SPT_LSB +: FLD_W] = FLD_W'(r_gidx);
  end

  assign w_beat_in = {S_AXIS_TLAST[r_gidx], w_user, w_tstrb[r_gidx], w_tdata[r_gidx]};

  always_comb begin
    w_state_nxt = r_state;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr;
    case (r_state)
      ST_IDLE: if (|w_req) begin
        w_state_nxt = ST_PKT;
        w_gidx_nxt  = IDX_W'(rr_pick(MAX_PORTS'(w_req), int'(r_rr), NPORTS));
      end
      default: if (w_acc_last) begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = r_gidx;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
      r_gidx  <= '0;
      r_rr    <= IDX_W'(NPORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gidx  <= w_gidx_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_cnt <= '0;
    else if (w_acc_last) r_cnt[r_gidx] <= r_cnt[r_gidx] + CNT_W'(1);
  end
  assign PKT_CNT = r_cnt;

  axis_skid2 #(.W(BEAT_W)) u_obuf (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_data  (w_beat_in),
    .i_valid (w_in_vld),
    .o_ready (w_buf_rdy),
    .o_data  (w_beat_out),
    .o_valid (M_AXIS_TVALID),
    .i_ready (M_AXIS_TREADY)
  );

  assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = w_beat_out;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;
  localparam int NP = 4, DW = 32, SW = 4, UW = 128, CW = 4;
  localparam int BW = 1 + UW + SW + DW;
  localparam int SPT = DW + SW + 16;
  typedef logic [BW-1:0] beat_t;

  logic ACLK = 1'b0, ARESET = 1'b0;
  logic [NP*DW-1:0] S_AXIS_TDATA = '0;
  logic [NP*SW-1:0] S_AXIS_TSTRB = '0;
  logic [NP*UW-1:0] S_AXIS_TUSER = '0;
  logic [NP-1:0]    S_AXIS_TLAST = '0, S_AXIS_TVALID = '0, S_AXIS_TREADY;
  logic [DW-1:0]    M_AXIS_TDATA;
  logic [SW-1:0]    M_AXIS_TSTRB;
  logic [UW-1:0]    M_AXIS_TUSER;
  logic             M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY = 1'b1;
  logic [NP-1:0]    PORT_EN = '0, GRANT;
  logic             BUSY;
  logic [NP*CW-1:0] PKT_CNT;

  axis_pkt_arbiter #(.NPORTS(NP), .DATA_W(DW), .USER_W(UW), .STAMP_SPT(1), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .PORT_EN(PORT_EN), .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0, n_err = 0;
  function automatic void chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // per-port source queues, driven one beat per cycle while non-empty
  beat_t srcq [NP][$];
  logic [NP-1:0] hs = '0;
  int cyc = 0;
  logic bp_on = 1'b0;
  logic [3:0] bp_pat = 4'b1001;

  function automatic beat_t mk(int port, logic [DW-1:0] d, bit last);
    logic [UW-1:0] u;
    u = {32'hCAFE_0000 | 32'(port), d ^ 32'h5A5A_5A5A, 32'h1234_5678,
         8'(8'hD0 + port), 8'hEE, 16'h0040};
    return {last, u, 4'(d[3:0] | 4'h1), d};
  endfunction

  task automatic push_pkt(int port, int n, logic [DW-1:0] base);
    for (int i = 0; i < n; i++) srcq[port].push_back(mk(port, base + DW'(i), i == n - 1));
  endtask

  always @(posedge ACLK) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
      if (srcq[p].size() > 0) begin
        {S_AXIS_TLAST[p], S_AXIS_TUSER[p*UW +: UW], S_AXIS_TSTRB[p*SW +: SW],
         S_AXIS_TDATA[p*DW +: DW]} = srcq[p][0];
        S_AXIS_TVALID[p] = 1'b1;
      end else S_AXIS_TVALID[p] = 1'b0;
    end
    M_AXIS_TREADY = bp_on ? bp_pat[2'(cyc)] : 1'b1;
  end

  // Model: owner = packet owner (-1 idle), in-flight beats = queue of cap 2.
  int m_owner = -1, m_rr = NP - 1;
  int m_cnt [NP];
  beat_t m_q[$];
  beat_t outlog[$];
  int acc_cnt = 0, first_acc = -1, first_out = -1, stall_cyc = 0;
  logic [NP-1:0] e_rdy, e_gnt, m_req;
  logic [NP*CW-1:0] e_cnt;
  beat_t m_b, act_b;
  bit m_acc, m_pop;

  always @(negedge ACLK) begin
    cyc++;
    act_b = {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA};
    if (ARESET) begin
      m_owner = -1; m_rr = NP - 1; m_q.delete(); hs = '0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      chk("rst_tvalid", M_AXIS_TVALID, 0);
      chk("rst_mbeat", act_b, 0);
      chk("rst_grant", GRANT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_sready", S_AXIS_TREADY, 0);
      chk("rst_cnt", PKT_CNT, 0);
    end else begin
      e_rdy = '0; e_gnt = '0; e_cnt = '0;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1;
        if (m_q.size() < 2) e_rdy[m_owner] = 1'b1;
      end
      for (int p = 0; p < NP; p++) e_cnt[p*CW +: CW] = CW'(m_cnt[p]);
      chk("grant", GRANT, e_gnt);
      chk("busy", BUSY, m_owner >= 0);
      chk("sready", S_AXIS_TREADY, e_rdy);
      chk("pkt_cnt", PKT_CNT, e_cnt);
      chk("mvalid", M_AXIS_TVALID, m_q.size() != 0);
      if (m_q.size() > 0) chk("mbeat", act_b, m_q[0]);
      hs = S_AXIS_TVALID & S_AXIS_TREADY;
      if (|hs) begin acc_cnt++; if (first_acc < 0) first_acc = cyc; end
      if (M_AXIS_TVALID && first_out < 0) first_out = cyc;
      if (BUSY && S_AXIS_TREADY == '0) stall_cyc++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) outlog.push_back(act_b);
      m_pop = m_q.size() > 0 && M_AXIS_TREADY;
      m_acc = m_owner >= 0 && S_AXIS_TVALID[m_owner] && m_q.size() < 2;
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) begin
        m_b = {S_AXIS_TLAST[m_owner], S_AXIS_TUSER[m_owner*UW +: UW],
               S_AXIS_TSTRB[m_owner*SW +: SW], S_AXIS_TDATA[m_owner*DW +: DW]};
        m_b[SPT +: 8] = 8'(m_owner);
        m_q.push_back(m_b);
        if (m_b[BW-1]) begin
          m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CW);
          m_rr = m_owner; m_owner = -1;
        end
      end else if (m_owner < 0) begin
        m_req = S_AXIS_TVALID & PORT_EN;
        for (int k = 1; k <= NP; k++)
          if (m_owner < 0 && m_req[(m_rr + k) % NP]) m_owner = (m_rr + k) % NP;
      end
    end
  end

  function automatic bit pending(logic [NP-1:0] msk);
    bit r = 0;
    for (int p = 0; p < NP; p++) if (msk[p] && srcq[p].size() > 0) r = 1;
    return r;
  endfunction

  task automatic wait_idle(string nm, logic [NP-1:0] msk);
    int n = 0;
    while (n < 400 && (pending(msk) || BUSY || M_AXIS_TVALID)) begin
      @(posedge ACLK); #2; n++;
    end
    chk({nm, "_done"}, n < 400, 1);
  endtask

  task automatic clr_logs();
    outlog.delete(); acc_cnt = 0; first_acc = -1; first_out = -1; stall_cyc = 0;
  endtask

  task automatic do_reset();
    @(posedge ACLK); #2;
    ARESET = 1'b1;
    for (int p = 0; p < NP; p++) srcq[p].delete();
    repeat (2) @(posedge ACLK);
    #2 ARESET = 1'b0;
    clr_logs();
  endtask

  initial begin
    #1 ARESET = 1'b1;
    do_reset();
    chk("lit_rst_cnt", PKT_CNT, 0);
    chk("lit_rst_grant", GRANT, 0);

    // single port, 4 beats
    PORT_EN = 4'b0001;
    push_pkt(0, 4, 32'h10);
    wait_idle("t1", 4'b0001);
    chk("t1_nbeats", outlog.size(), 4);
    for (int i = 0; i < outlog.size(); i++) begin
      chk("t1_data", outlog[i][DW-1:0], 32'h10 + i);
      chk("t1_spt", outlog[i][SPT +: 8], 0);
      chk("t1_last", outlog[i][BW-1], i == 3);
    end
    chk("t1_cnt", PKT_CNT, 16'h0001);
    chk("t1_grant", GRANT, 0);
    chk("t1_latency", first_out - first_acc, 1);

    // round robin, two 2-beat packets per port
    do_reset();
    PORT_EN = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 2, 32'(p * 256 + r * 16));
    wait_idle("t2", 4'b1111);
    chk("t2_nbeats", outlog.size(), 16);
    for (int k = 0; k < outlog.size() / 2; k++) begin
      chk("t2_spt0", outlog[2*k][SPT +: 8], k % 4);
      chk("t2_spt1", outlog[2*k+1][SPT +: 8], k % 4);
      chk("t2_last", {outlog[2*k][BW-1], outlog[2*k+1][BW-1]}, 2'b01);
    end
    chk("t2_cnt", PKT_CNT, 16'h2222);

    // backpressure 1,0,0,1 over a 6-beat packet
    do_reset();
    PORT_EN = 4'b0001;
    bp_on = 1'b1;
    push_pkt(0, 6, 32'hA0);
    wait_idle("t3", 4'b0001);
    bp_on = 1'b0;
    chk("t3_nbeats", outlog.size(), 6);
    for (int i = 0; i < outlog.size(); i++) chk("t3_data", outlog[i][DW-1:0], 32'hA0 + i);
    chk("t3_stalled", stall_cyc > 0, 1);
    chk("t3_cnt", PKT_CNT, 16'h0001);

    // enable mask: only port 2, then disable mid-packet
    do_reset();
    PORT_EN = 4'b0100;
    push_pkt(1, 3, 32'h100);
    push_pkt(2, 6, 32'h200);
    for (int n = 0; n < 20 && !BUSY; n++) begin @(posedge ACLK); #2; end
    repeat (2) @(posedge ACLK);
    #2;
    chk("t4_grant_mid", GRANT, 4'b0100);
    PORT_EN = 4'b0000;
    wait_idle("t4", 4'b0100);
    repeat (10) @(posedge ACLK);
    #2;
    chk("t4_grant_after", GRANT, 0);
    chk("t4_busy_after", BUSY, 0);
    chk("t4_nbeats", outlog.size(), 6);
    for (int i = 0; i < outlog.size(); i++) chk("t4_spt", outlog[i][SPT +: 8], 2);
    chk("t4_cnt", PKT_CNT, 16'h0100);
    chk("t4_p1_unserved", srcq[1].size(), 3);

    // counter wrap at 2^4
    do_reset();
    PORT_EN = 4'b1000;
    for (int i = 0; i < 17; i++) push_pkt(3, 1, 32'(i));
    wait_idle("t5", 4'b1000);
    chk("t5_nbeats", outlog.size(), 17);
    chk("t5_cnt", PKT_CNT, 16'h1000);

    // reset after beat 2 of a 5-beat packet
    do_reset();
    PORT_EN = 4'b0001;
    push_pkt(0, 5, 32'h50);
    for (int n = 0; n < 30 && acc_cnt < 2; n++) begin @(posedge ACLK); #2; end
    chk("t6_reach", acc_cnt >= 2, 1);
    chk("t6_pre_tvalid", M_AXIS_TVALID, 1);
    ARESET = 1'b1;
    for (int p = 0; p < NP; p++) srcq[p].delete();
    #1;
    chk("t6_async_tvalid", M_AXIS_TVALID, 0);
    chk("t6_async_cnt", PKT_CNT, 0);
    repeat (2) @(posedge ACLK);
    #2 ARESET = 1'b0;
    clr_logs();
    PORT_EN = 4'b0011;
    push_pkt(1, 3, 32'h70);
    wait_idle("t6", 4'b0011);
    chk("t6_nbeats", outlog.size(), 3);
    for (int i = 0; i < outlog.size(); i++) begin
      chk("t6_data", outlog[i][DW-1:0], 32'h70 + i);
      chk("t6_spt", outlog[i][SPT +: 8], 1);
    end
    chk("t6_cnt", PKT_CNT, 16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
